// File: rtl/myproject_mul_share_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package myproject_mul_share_pkg;

   localparam int A_W      = 7;    // unsigned weight magnitude
   localparam int B_W      = 16;   // signed activation
   localparam int P_W      = 23;   // exact signed product width
   localparam int ID_MAX_W = 3;    // enough to tag up to 8 requesters

   // Operand bundle captured in the first pipeline stage.
   typedef struct packed {
      logic [A_W-1:0]      a;
      logic [B_W-1:0]      b;
      logic [ID_MAX_W-1:0] id;
   } mul_req_t;

endpackage

// File: rtl/myproject_mul_mul_7ns_16s_23_1_1.sv
// Combinational 7-bit unsigned x 16-bit signed multiplier, exact in 23 bits.
module myproject_mul_mul_7ns_16s_23_1_1 (
   input  logic [6:0]  din0,
   input  logic [15:0] din1,
   output logic [22:0] dout
);

   logic signed [22:0] a_ext_s;
   logic signed [22:0] b_ext_s;

   // Zero-extend the magnitude, sign-extend the activation, then multiply.
   always_comb begin
      a_ext_s = {16'b0, din0};
      b_ext_s = {{7{din1[15]}}, din1};
      dout    = a_ext_s * b_ext_s;
   end

endmodule

// File: rtl/myproject_mul_rr_pick.sv
// Rotate-priority picker: first valid lane at or after ptr, wrapping modulo NREQ.
module myproject_mul_rr_pick #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);

   // Scan NREQ candidates starting at ptr; the first valid one wins.
   always_comb begin
      int cand;
      cand    = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = (int'(ptr_i) + k) % NREQ;
         if (!any_o && valid_i[cand]) begin
            grant_o[cand] = 1'b1;
            idx_o         = ID_W'(cand);
            any_o         = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin sharing of one multiplier among NREQ lanes: S1 operands, S2 product.
module myproject_mul_share_arb
   import myproject_mul_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*A_W-1:0] req_a,
   input  logic [NREQ*B_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic [P_W-1:0]    rsp_p
);

   logic [A_W-1:0]  a_arr_s [NREQ];
   logic [B_W-1:0]  b_arr_s [NREQ];

   logic            s1_v_q, s1_v_d;
   mul_req_t        s1_q, s1_d;
   logic            s2_v_q, s2_v_d;
   logic [P_W-1:0]  s2_p_q, s2_p_d;
   logic [ID_W-1:0] s2_id_q, s2_id_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic [NREQ-1:0] grant_s;
   logic [ID_W-1:0] pick_idx_s;
   logic            pick_any_s;
   logic [P_W-1:0]  mul_p_s;
   logic            adv1_s, adv2_s, accept_s;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr_s[g] = req_a[g*A_W +: A_W];
      assign b_arr_s[g] = req_b[g*B_W +: B_W];
   end

   myproject_mul_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant_s),
      .idx_o   (pick_idx_s),
      .any_o   (pick_any_s)
   );

   myproject_mul_mul_7ns_16s_23_1_1 u_mul (
      .din0 (s1_q.a),
      .din1 (s1_q.b),
      .dout (mul_p_s)
   );

   // Advance chain and handshake; ready is held off while reset is asserted.
   always_comb begin
      adv2_s    = !s2_v_q || rsp_ready;
      adv1_s    = !s1_v_q || adv2_s;
      req_ready = adv1_s && ap_rst_n ? grant_s : '0;
      accept_s  = pick_any_s && adv1_s && ap_rst_n;
   end

   // Next-state for S1 operands, round-robin pointer and S2 product.
   always_comb begin
      s1_v_d  = s1_v_q;
      s1_d    = s1_q;
      ptr_d   = ptr_q;
      s2_v_d  = s2_v_q;
      s2_p_d  = s2_p_q;
      s2_id_d = s2_id_q;
      if (adv1_s) begin
         if (accept_s) begin
            s1_v_d = 1'b1;
            s1_d.a  = a_arr_s[pick_idx_s];
            s1_d.b  = b_arr_s[pick_idx_s];
            s1_d.id = ID_MAX_W'(pick_idx_s);
            if (pick_idx_s == ID_W'(NREQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = pick_idx_s + ID_W'(1);
            end
         end else begin
            s1_v_d = 1'b0;
         end
      end else begin
         s1_v_d = s1_v_q;
      end
      if (adv2_s) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_p_d  = mul_p_s;
            s2_id_d = s1_q.id[ID_W-1:0];
         end else begin
            s2_p_d = s2_p_q;
         end
      end else begin
         s2_v_d = s2_v_q;
      end
   end

   // Pipeline and pointer registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_v_q  <= 1'b0;
         s1_q    <= '0;
         s2_v_q  <= 1'b0;
         s2_p_q  <= '0;
         s2_id_q <= '0;
         ptr_q   <= '0;
      end else begin
         s1_v_q  <= s1_v_d;
         s1_q    <= s1_d;
         s2_v_q  <= s2_v_d;
         s2_p_q  <= s2_p_d;
         s2_id_q <= s2_id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign rsp_valid = s2_v_q;
   assign rsp_id    = s2_id_q;
   assign rsp_p     = s2_p_q;

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed and randomised checks of the shared-multiplier arbiter.
module tb_myproject_mul_share_arb;

   localparam int NREQ = 4;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [27:0] req_a;
   logic [63:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [22:0] rsp_p;

   int pass_cnt = 0;
   int total_cnt = 0;

   myproject_mul_share_arb #(.NREQ(4), .ID_W(2)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic step;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [6:0] a, input logic [15:0] b);
      req_a[i*7 +: 7]   = a;
      req_b[i*16 +: 16] = b;
   endtask

   task automatic reset_dut;
      ap_rst_n  = 1'b0;
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      req_a     = 28'd0;
      req_b     = 64'd0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
   endtask

   task automatic test_reset;
      ap_rst_n  = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #13;
      total_cnt++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_p !== 23'd0) begin
         $display("FAIL reset_rsp got v=%b id=%0d p=%0d want v=0 id=0 p=0", rsp_valid, rsp_id, rsp_p);
      end else pass_cnt++;
      total_cnt++;
      if (req_ready !== 4'b0000) begin
         $display("FAIL reset_ready got %b want 0000", req_ready);
      end else pass_cnt++;
      reset_dut();
   endtask

   task automatic test_single;
      logic [22:0] exp_p;
      reset_dut();
      exp_p = -23'sd4161536;
      set_lane(0, 7'd127, 16'h8000);
      req_valid = 4'b0001;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0001) begin
         $display("FAIL single_ready got %b want 0001", req_ready);
      end else pass_cnt++;
      step();
      req_valid = 4'b0000;
      total_cnt++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL single_early got %b want 0", rsp_valid);
      end else pass_cnt++;
      step();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== exp_p) begin
         $display("FAIL single_rsp got v=%b id=%0d p=%0d want v=1 id=0 p=-4161536", rsp_valid, rsp_id, $signed(rsp_p));
      end else pass_cnt++;
      step();
      total_cnt++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL single_drain got %b want 0", rsp_valid);
      end else pass_cnt++;
   endtask

   task automatic test_round_robin;
      logic [3:0]  exp_r;
      logic [22:0] exp_p;
      int e;
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_lane(i, 7'(i + 1), 16'd100);
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         exp_r = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
         #1;
         total_cnt++;
         if (req_ready !== exp_r) begin
            $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, exp_r);
         end else pass_cnt++;
         step();
         if (c >= 1 && c <= 8) begin
            e = ((c - 1) % 4 + 1) * 100;
            exp_p = e[22:0];
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_p !== exp_p) begin
               $display("FAIL rr_rsp c=%0d got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d", c, rsp_valid, rsp_id, $signed(rsp_p), (c - 1) % 4, e);
            end else pass_cnt++;
         end else if (c == 9) begin
            total_cnt++;
            if (rsp_valid !== 1'b0) begin
               $display("FAIL rr_tail got %b want 0", rsp_valid);
            end else pass_cnt++;
         end
      end
   endtask

   task automatic test_backpressure;
      int exp_id [5] = '{1, 2, 3, 0, 1};
      logic [22:0] exp_p;
      int e;
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_lane(i, 7'(i + 1), -16'sd1000);
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0001) begin
         $display("FAIL bp_fill0 got %b want 0001", req_ready);
      end else pass_cnt++;
      step();
      total_cnt++;
      if (req_ready !== 4'b0010) begin
         $display("FAIL bp_fill1 got %b want 0010", req_ready);
      end else pass_cnt++;
      step();
      e = -1000;
      exp_p = e[22:0];
      for (int s = 0; s < 5; s++) begin
         #1;
         total_cnt++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== exp_p) begin
            $display("FAIL bp_hold s=%0d got rdy=%b v=%b id=%0d p=%0d want rdy=0000 v=1 id=0 p=-1000", s, req_ready, rsp_valid, rsp_id, $signed(rsp_p));
         end else pass_cnt++;
         step();
      end
      rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0100) begin
         $display("FAIL bp_release got %b want 0100", req_ready);
      end else pass_cnt++;
      for (int k = 0; k < 5; k++) begin
         req_valid = (k < 4) ? 4'b1111 : 4'b0000;
         step();
         e = -(exp_id[k] + 1) * 1000;
         exp_p = e[22:0];
         total_cnt++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[k]) || rsp_p !== exp_p) begin
            $display("FAIL bp_order k=%0d got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d", k, rsp_valid, rsp_id, $signed(rsp_p), exp_id[k], e);
         end else pass_cnt++;
      end
      step();
      total_cnt++;
      if (rsp_valid !== 1'b0) begin
         $display("FAIL bp_drain got %b want 0", rsp_valid);
      end else pass_cnt++;
   endtask

   task automatic test_fairness;
      logic [3:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_lane(i, 7'd3, 16'd7);
      for (int c = 0; c < 6; c++) begin
         req_valid = 4'b0001 | ((c >= 3) ? 4'b0100 : 4'b0000);
         #1;
         total_cnt++;
         if (req_ready !== exp_g[c]) begin
            $display("FAIL fair_grant c=%0d got %b want %b", c, req_ready, exp_g[c]);
         end else pass_cnt++;
         step();
      end
      req_valid = 4'b0000;
      repeat (3) step();
   endtask

   task automatic test_reset_mid;
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_lane(i, 7'(i + 5), 16'd9);
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      step();
      step();
      total_cnt++;
      if (rsp_valid !== 1'b1) begin
         $display("FAIL rmid_full got %b want 1", rsp_valid);
      end else pass_cnt++;
      #2;
      ap_rst_n = 1'b0;
      #1;
      total_cnt++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         $display("FAIL rmid_async got v=%b rdy=%b want v=0 rdy=0000", rsp_valid, req_ready);
      end else pass_cnt++;
      step();
      ap_rst_n  = 1'b1;
      rsp_ready = 1'b1;
      #1;
      total_cnt++;
      if (req_ready !== 4'b0001) begin
         $display("FAIL rmid_first got %b want 0001", req_ready);
      end else pass_cnt++;
      step();
      req_valid = 4'b0000;
      step();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 23'd45) begin
         $display("FAIL rmid_rsp got v=%b id=%0d p=%0d want v=1 id=0 p=45", rsp_valid, rsp_id, $signed(rsp_p));
      end else pass_cnt++;
      step();
   endtask

   task automatic test_random;
      logic        m_s1v, m_s2v;
      int          m_s1id, m_s2id, m_ptr, g, cand, e;
      logic [22:0] m_s1p, m_s2p, pv;
      logic        adv1, adv2;
      logic [3:0]  exp_r;
      logic [6:0]  ra;
      logic [15:0] rb;
      reset_dut();
      m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = 0;
      m_s1id = 0; m_s2id = 0; m_s1p = 23'd0; m_s2p = 23'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            ra = 7'($urandom);
            rb = 16'($urandom);
            set_lane(i, ra, rb);
         end
         adv2 = !m_s2v || rsp_ready;
         adv1 = !m_s1v || adv2;
         g = -1;
         for (int k = 0; k < NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[cand]) g = cand;
         end
         exp_r = (adv1 && g >= 0) ? 4'(1 << g) : 4'b0000;
         #1;
         total_cnt++;
         if (req_ready !== exp_r) begin
            $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, req_ready, exp_r);
         end else pass_cnt++;
         if (adv2) begin
            m_s2v = m_s1v;
            if (m_s1v) begin
               m_s2id = m_s1id;
               m_s2p  = m_s1p;
            end
         end
         if (adv1) begin
            if (g >= 0) begin
               m_s1v  = 1'b1;
               m_s1id = g;
               ra = req_a[g*7 +: 7];
               rb = req_b[g*16 +: 16];
               e = int'(ra) * int'($signed(rb));
               pv = e[22:0];
               m_s1p = pv;
               m_ptr = (g + 1) % NREQ;
            end else begin
               m_s1v = 1'b0;
            end
         end
         step();
         total_cnt++;
         if (rsp_valid !== m_s2v || (m_s2v && (rsp_id !== 2'(m_s2id) || rsp_p !== m_s2p))) begin
            $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d p=%0d want v=%b id=%0d p=%0d", cyc, rsp_valid, rsp_id, $signed(rsp_p), m_s2v, m_s2id, $signed(m_s2p));
         end else pass_cnt++;
      end
   endtask

   initial begin
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      req_a     = 28'd0;
      req_b     = 64'd0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
